// File: rtl/mul32_m_seq.sv
// RV32M multiply sequencer around an unsigned shift-add core: takes operand magnitudes in,
// runs the core for CORE_CYCLES clocks, re-applies the sign and returns the selected half.
module mul32_m_seq #(
  parameter int CORE_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        core_rst,
  output logic [31:0] core_op1,
  output logic [31:0] core_op2,
  input  logic [63:0] core_res
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [5:0] RUN_LAST  = 6'(CORE_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  run_cnt;
  logic [1:0]  op;
  logic        neg;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] res_word;
  logic        accept;
  logic        rs1_neg;
  logic        rs2_neg;
  logic [63:0] prod;

  assign accept  = in_valid && (state == IDLE);
  assign rs1_neg = ((funct3 == OP_MULH) || (funct3 == OP_MULHSU)) && rs1[31];
  assign rs2_neg = (funct3 == OP_MULH) && rs2[31];

  // 0x80000000 negates to itself, which is the right unsigned magnitude.
  assign prod = neg ? (~core_res + 64'd1) : core_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CLR;
      CLR:  state_nxt = RUN;
      RUN:  if (run_cnt == RUN_LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt  <= 6'd0;
      op       <= 2'b00;
      neg      <= 1'b0;
      op1      <= 32'd0;
      op2      <= 32'd0;
      res_word <= 32'd0;
    end else begin
      if (accept) begin
        op  <= funct3;
        neg <= rs1_neg ^ rs2_neg;
        op1 <= rs1_neg ? (~rs1 + 32'd1) : rs1;
        op2 <= rs2_neg ? (~rs2 + 32'd1) : rs2;
      end
      if (state == CLR) begin
        run_cnt <= 6'd0;
      end else if (state == RUN) begin
        run_cnt <= run_cnt + 6'd1;
      end
      // Core is still frozen on its final sum during FIX.
      if (state == FIX) begin
        res_word <= (op == OP_MUL) ? prod[31:0] : prod[63:32];
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = res_word;
  assign core_rst  = (state != RUN);
  assign core_op1  = op1;
  assign core_op2  = op2;

endmodule

// File: tb/tb_mul32_m_seq.sv
// Bench for mul32_m_seq: behavioural core stand-in, cycle-level reference model and
// directed plus randomized multiply requests with output stalls.
module tb_mul32_m_seq;
  localparam int CC = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  funct3 = 2'b00;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        core_rst;
  logic [31:0] core_op1;
  logic [31:0] core_op2;
  logic [63:0] core_res = 64'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge = 0;
  int ccnt = 0;

  mul32_m_seq #(.CORE_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_rst(core_rst), .core_op1(core_op1), .core_op2(core_op2),
    .core_res(core_res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: after k unfrozen edges it holds op1 * (low k bits of op2).
  always @(posedge clk) begin
    if (core_rst) begin
      ccnt     <= 0;
      core_res <= 64'd0;
    end else begin
      logic [63:0] mask;
      int k;
      k = ccnt + 1;
      mask = (k >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << k) - 64'd1);
      if (ccnt < CC) ccnt <= ccnt + 1;
      core_res <= {32'd0, core_op1} * ({32'd0, core_op2} & mask);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rs1_signed(input logic [1:0] f);
    return (f == 2'b01) || (f == 2'b10);
  endfunction

  function automatic logic rs2_signed(input logic [1:0] f);
    return f == 2'b01;
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    longint x;
    x = sgn ? longint'($signed(v)) : longint'({32'd0, v});
    if (x < 0) x = -x;
    return x[31:0];
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint x;
    longint y;
    logic [63:0] p;
    x = rs1_signed(f) ? longint'($signed(a)) : longint'({32'd0, a});
    y = rs2_signed(f) ? longint'($signed(b)) : longint'({32'd0, b});
    p = x * y;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Reference model: one request in flight, timing derived from the accept edge.
  logic        busy = 1'b0;
  int          m_acc = 0;
  logic [31:0] m_exp = 32'd0;
  logic [31:0] m_held = 32'd0;
  logic [31:0] m_mag1 = 32'd0;
  logic [31:0] m_mag2 = 32'd0;

  always @(negedge clk) begin
    logic e_valid;
    logic e_rst;
    e_valid = busy && (cyc >= m_acc + CC + 2);
    e_rst   = !(busy && (cyc >= m_acc + 1) && (cyc <= m_acc + CC));
    if (cyc >= 1) begin
      chk("in_ready", in_ready, !busy);
      chk("out_valid", out_valid, e_valid);
      chk("out_data", out_data, e_valid ? m_exp : m_held);
      chk("core_rst", core_rst, e_rst);
      chk("core_op1", core_op1, m_mag1);
      chk("core_op2", core_op2, m_mag2);
      chk("ready_valid_excl", in_ready && out_valid, 1'b0);
    end
    if (rst) begin
      busy   = 1'b0;
      m_held = 32'd0;
      m_mag1 = 32'd0;
      m_mag2 = 32'd0;
    end else if (busy) begin
      if (e_valid && out_ready) begin
        busy   = 1'b0;
        m_held = m_exp;
      end
    end else if (in_valid) begin
      busy   = 1'b1;
      m_acc  = cyc + 1;
      m_exp  = ref_res(funct3, rs1, rs2);
      m_mag1 = mag(rs1, rs1_signed(funct3));
      m_mag2 = mag(rs2, rs2_signed(funct3));
    end
  end

  task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    in_valid = 1'b1;
    funct3 = f;
    rs1 = a;
    rs2 = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    acc_edge = cyc;
    in_valid = 1'b0;
    funct3 = 2'($urandom_range(0, 3));
    rs1 = $urandom;
    rs2 = $urandom;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_valid", out_valid, 1'b1);
    if (out_valid) chk("latency", 64'(cyc - acc_edge), 64'(CC + 2));
  endtask

  task automatic finish_op(input bit do_lit, input logic [31:0] lit, input bit rand_stall);
    int n;
    logic r;
    if (do_lit) chk("result_literal", out_data, lit);
    n = 0;
    do begin
      r = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = r;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 200);
    chk("timeout_handshake", r, 1'b1);
    out_ready = 1'b0;
  endtask

  task automatic run_lit(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit);
    chk("model_pin", ref_res(f, a, b), lit);
    send(f, a, b);
    wait_valid();
    finish_op(1'b1, lit, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_core_op1", core_op1, 32'd0);
    chk("rst_core_op2", core_op2, 32'd0);

    run_lit(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_lit(2'b00, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFF9);
    run_lit(2'b01, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF);
    run_lit(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_lit(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

    // Back-pressure, with a second request offered on the handshake cycle.
    send(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_valid();
    held = out_data;
    chk("bp_result", out_data, ref_res(2'b11, 32'h1234_5678, 32'h9ABC_DEF0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_data_stable", out_data, held);
      chk("bp_in_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    funct3 = 2'b00;
    rs1 = 32'd3;
    rs2 = 32'd5;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_not_accepted_on_handshake", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp_accepted_next_idle", in_ready, 1'b0);
    acc_edge = cyc;
    in_valid = 1'b0;
    wait_valid();
    finish_op(1'b1, 32'h0000_000F, 1'b0);

    // Reset while the core is running at count 15.
    send(2'b01, 32'hDEAD_BEEF, 32'h8765_4321);
    repeat (16) begin
      @(posedge clk); #1;
    end
    chk("mid_run_core_rst", core_rst, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_out_valid", out_valid, 1'b0);
    chk("mr_in_ready", in_ready, 1'b1);
    chk("mr_core_rst", core_rst, 1'b1);
    run_lit(2'b11, 32'd3, 32'd5, 32'h0000_0000);
    run_lit(2'b00, 32'd3, 32'd5, 32'h0000_000F);

    for (int i = 0; i < 1000; i++) begin
      logic [1:0] f;
      logic [31:0] a;
      logic [31:0] b;
      f = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(f, a, b);
      wait_valid();
      finish_op(1'b0, 32'd0, 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
